// File: rtl/mc_resp_pkg.sv
// Shared command/response codes and the address-to-word-index rule
// used by the MC port responder and its request/response queues.
package mc_resp_pkg;

  typedef enum logic [2:0] {
    CMD_RD = 3'd1,
    CMD_WR = 3'd2
  } rq_cmd_e;

  typedef enum logic [2:0] {
    RS_RDATA = 3'd2,
    RS_WRCMP = 3'd3
  } rs_cmd_e;

  // Every access is one 64-bit word, so the index starts above the byte offset.
  localparam int WORD_LSB = 3;

  function automatic int word_idx_msb(input int mem_aw);
    return mem_aw + WORD_LSB - 1;
  endfunction

endpackage

// File: rtl/mc_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push to a full FIFO succeeds
// only when a pop happens in the same cycle, otherwise it is dropped.
module mc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             drop,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign rd_data = store[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mc_port_responder.sv
// Memory-controller port model: queues requests, executes them in order
// against a local 64-bit memory and returns responses after a fixed latency.
module mc_port_responder
  import mc_resp_pkg::*;
#(
  parameter int RTNCTL_WIDTH = 32,
  parameter int MEM_AW       = 8,
  parameter int LATENCY      = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int STALL_MARGIN = 2
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic                    mc_rq_vld,
  input  logic [2:0]              mc_rq_cmd,
  input  logic [3:0]              mc_rq_scmd,
  input  logic [47:0]             mc_rq_vadr,
  input  logic [1:0]              mc_rq_size,
  input  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  input  logic [63:0]             mc_rq_data,
  input  logic                    mc_rq_flush,
  output logic                    mc_rq_stall,
  output logic                    mc_rs_vld,
  output logic [2:0]              mc_rs_cmd,
  output logic [3:0]              mc_rs_scmd,
  output logic [63:0]             mc_rs_data,
  output logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  input  logic                    mc_rs_stall,
  output logic                    mc_rs_flush_cmplt,
  output logic [15:0]             err_unsup_cnt,
  output logic                    ovf_err
);

  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_MSB = word_idx_msb(MEM_AW);
  localparam int RQ_W    = 3 + MEM_AW + RTNCTL_WIDTH + 64;
  localparam int RS_W    = 3 + RTNCTL_WIDTH + 64;

  logic [RQ_W-1:0]         rqf_wdata;
  logic [RQ_W-1:0]         rqf_rdata;
  logic                    rqf_pop;
  logic                    rqf_full;
  logic                    rqf_empty;
  logic                    rqf_drop;
  logic [CW-1:0]           rqf_count;

  logic [RS_W-1:0]         rsf_wdata;
  logic [RS_W-1:0]         rsf_rdata;
  logic                    rsf_full;
  logic                    rsf_empty;
  logic                    rsf_drop;
  logic [CW-1:0]           rsf_count;

  logic [2:0]              head_cmd;
  logic [MEM_AW-1:0]       head_idx;
  logic [RTNCTL_WIDTH-1:0] head_rtnctl;
  logic [63:0]             head_data;
  logic [63:0]             rd_data;

  logic [2:0]              rsf_cmd;
  logic [RTNCTL_WIDTH-1:0] rsf_rtnctl;
  logic [63:0]             rsf_data;

  logic                    exec_rd;
  logic                    exec_wr;
  logic                    exec_unsup;
  logic [31:0]             inflight;
  logic                    all_empty;
  logic                    flush_pending;

  logic                    pipe_vld    [LATENCY];
  logic [2:0]              pipe_cmd    [LATENCY];
  logic [63:0]             pipe_data   [LATENCY];
  logic [RTNCTL_WIDTH-1:0] pipe_rtnctl [LATENCY];

  logic [63:0]             mem [2**MEM_AW];

  logic                    unused_ok;
  assign unused_ok = ^{mc_rq_scmd, mc_rq_size, mc_rq_vadr[47:IDX_MSB+1],
                       mc_rq_vadr[WORD_LSB-1:0], rqf_full, rsf_full, rsf_drop};

  assign rqf_wdata = {mc_rq_cmd, mc_rq_vadr[IDX_MSB:WORD_LSB], mc_rq_rtnctl, mc_rq_data};
  assign {head_cmd, head_idx, head_rtnctl, head_data} = rqf_rdata;

  mc_sync_fifo #(.WIDTH(RQ_W), .DEPTH(FIFO_DEPTH)) rqf (
    .clk     (clk),
    .rst     (i_reset),
    .push    (mc_rq_vld),
    .wr_data (rqf_wdata),
    .pop     (rqf_pop),
    .rd_data (rqf_rdata),
    .full    (rqf_full),
    .empty   (rqf_empty),
    .drop    (rqf_drop),
    .count   (rqf_count)
  );

  // Only execute when every in-flight result is guaranteed a response-queue slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + 32'(pipe_vld[i]);
  end

  assign rqf_pop    = !rqf_empty && ((32'(rsf_count) + inflight) < 32'(FIFO_DEPTH));
  assign exec_rd    = rqf_pop && (head_cmd == CMD_RD);
  assign exec_wr    = rqf_pop && (head_cmd == CMD_WR);
  assign exec_unsup = rqf_pop && !(head_cmd == CMD_RD) && !(head_cmd == CMD_WR);
  assign rd_data    = mem[head_idx];

  always_ff @(posedge clk) begin
    if (exec_wr) mem[head_idx] <= head_data;
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld[i]    <= 1'b0;
        pipe_cmd[i]    <= '0;
        pipe_data[i]   <= '0;
        pipe_rtnctl[i] <= '0;
      end
    end else begin
      pipe_vld[0]    <= exec_rd || exec_wr;
      pipe_cmd[0]    <= exec_rd ? RS_RDATA : RS_WRCMP;
      pipe_data[0]   <= exec_rd ? rd_data : 64'd0;
      pipe_rtnctl[0] <= head_rtnctl;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i]    <= pipe_vld[i-1];
        pipe_cmd[i]    <= pipe_cmd[i-1];
        pipe_data[i]   <= pipe_data[i-1];
        pipe_rtnctl[i] <= pipe_rtnctl[i-1];
      end
    end
  end

  assign rsf_wdata = {pipe_cmd[LATENCY-1], pipe_rtnctl[LATENCY-1], pipe_data[LATENCY-1]};
  assign {rsf_cmd, rsf_rtnctl, rsf_data} = rsf_rdata;

  mc_sync_fifo #(.WIDTH(RS_W), .DEPTH(FIFO_DEPTH)) rsf (
    .clk     (clk),
    .rst     (i_reset),
    .push    (pipe_vld[LATENCY-1]),
    .wr_data (rsf_wdata),
    .pop     (mc_rs_vld),
    .rd_data (rsf_rdata),
    .full    (rsf_full),
    .empty   (rsf_empty),
    .drop    (rsf_drop),
    .count   (rsf_count)
  );

  assign mc_rs_vld    = !rsf_empty && !mc_rs_stall;
  assign mc_rs_cmd    = mc_rs_vld ? rsf_cmd : 3'd0;
  assign mc_rs_scmd   = 4'd0;
  assign mc_rs_data   = mc_rs_vld ? rsf_data : 64'd0;
  assign mc_rs_rtnctl = mc_rs_vld ? rsf_rtnctl : '0;

  assign all_empty         = rqf_empty && (inflight == 32'd0) && rsf_empty && !mc_rq_vld;
  assign mc_rs_flush_cmplt = flush_pending && all_empty;

  // Flushes that arrive while one is pending fold into the same completion.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      flush_pending <= 1'b0;
      mc_rq_stall   <= 1'b0;
      ovf_err       <= 1'b0;
      err_unsup_cnt <= '0;
    end else begin
      flush_pending <= (flush_pending && !mc_rs_flush_cmplt) || mc_rq_flush;
      mc_rq_stall   <= (CW'(FIFO_DEPTH) - rqf_count) <= CW'(STALL_MARGIN);
      ovf_err       <= ovf_err || rqf_drop;
      if (exec_unsup && (err_unsup_cnt != 16'hFFFF)) err_unsup_cnt <= err_unsup_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mc_port_responder.sv
// Randomised self-checking bench for mc_port_responder: a scoreboard of
// expected responses is built from a word-level memory model at issue time.
module tb_mc_port_responder;

  localparam int DEPTH = 8;
  localparam int LAT   = 4;
  localparam logic [2:0] RD = 3'd1, WR = 3'd2, RDATA = 3'd2, WRCMP = 3'd3;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        mc_rq_vld;
  logic [2:0]  mc_rq_cmd;
  logic [3:0]  mc_rq_scmd;
  logic [47:0] mc_rq_vadr;
  logic [1:0]  mc_rq_size;
  logic [31:0] mc_rq_rtnctl;
  logic [63:0] mc_rq_data;
  logic        mc_rq_flush;
  logic        mc_rq_stall;
  logic        mc_rs_vld;
  logic [2:0]  mc_rs_cmd;
  logic [3:0]  mc_rs_scmd;
  logic [63:0] mc_rs_data;
  logic [31:0] mc_rs_rtnctl;
  logic        mc_rs_stall;
  logic        mc_rs_flush_cmplt;
  logic [15:0] err_unsup_cnt;
  logic        ovf_err;

  typedef struct { logic [2:0] cmd; logic [63:0] data; logic [31:0] rtn; } exp_t;
  typedef struct { int cyc; logic [2:0] cmd; logic [3:0] scmd; logic [63:0] data; logic [31:0] rtn; } got_t;

  exp_t        exp_q[$];
  got_t        got[$];
  int          flush_cyc[$];
  logic [63:0] model_mem [16];
  int          model_unsup = 0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  mc_port_responder dut (
    .clk               (clk),
    .i_reset           (i_reset),
    .mc_rq_vld         (mc_rq_vld),
    .mc_rq_cmd         (mc_rq_cmd),
    .mc_rq_scmd        (mc_rq_scmd),
    .mc_rq_vadr        (mc_rq_vadr),
    .mc_rq_size        (mc_rq_size),
    .mc_rq_rtnctl      (mc_rq_rtnctl),
    .mc_rq_data        (mc_rq_data),
    .mc_rq_flush       (mc_rq_flush),
    .mc_rq_stall       (mc_rq_stall),
    .mc_rs_vld         (mc_rs_vld),
    .mc_rs_cmd         (mc_rs_cmd),
    .mc_rs_scmd        (mc_rs_scmd),
    .mc_rs_data        (mc_rs_data),
    .mc_rs_rtnctl      (mc_rs_rtnctl),
    .mc_rs_stall       (mc_rs_stall),
    .mc_rs_flush_cmplt (mc_rs_flush_cmplt),
    .err_unsup_cnt     (err_unsup_cnt),
    .ovf_err           (ovf_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Responses and flush pulses are captured mid-cycle, stamped with the cycle number.
  always @(negedge clk) begin
    if (mc_rs_vld) got.push_back('{cyc, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl});
    if (mc_rs_flush_cmplt) flush_cyc.push_back(cyc);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mc_rq_vld   = 1'b0;
    mc_rq_flush = 1'b0;
    mc_rq_cmd   = 3'd0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one request for the current cycle and record what it should return.
  task automatic drive_req(input logic [2:0] cmd, input int idx, input logic [63:0] data,
                           input logic [31:0] rtn, input bit keep);
    logic [47:0] v;
    v           = {16'($urandom), 32'($urandom)};
    v[10:3]     = 8'(idx);
    mc_rq_vld   = 1'b1;
    mc_rq_cmd   = cmd;
    mc_rq_scmd  = 4'($urandom);
    mc_rq_size  = 2'($urandom);
    mc_rq_vadr  = v;
    mc_rq_data  = data;
    mc_rq_rtnctl = rtn;
    if (keep) begin
      if (cmd == RD) exp_q.push_back('{RDATA, model_mem[idx], rtn});
      else if (cmd == WR) begin
        model_mem[idx] = data;
        exp_q.push_back('{WRCMP, 64'd0, rtn});
      end else model_unsup++;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    vectors++;
    if ({mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
         mc_rs_flush_cmplt, err_unsup_cnt, ovf_err} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got vld=%b err=%h ovf=%b stall=%b, required all 0",
               mc_rs_vld, err_unsup_cnt, ovf_err, mc_rq_stall);
    end
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    model_unsup = 0;
    @(negedge clk);
    vectors++;
    if ({mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
         mc_rs_flush_cmplt, err_unsup_cnt, ovf_err} !== '0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_outputs: got vld=%b err=%h ovf=%b stall=%b, required all 0",
               mc_rs_vld, err_unsup_cnt, ovf_err, mc_rq_stall);
    end
    tick();
  endtask

  task automatic test_fill();
    got.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      drive_req(WR, i, {$urandom, $urandom}, 32'(i), 1'b1);
      tick();
    end
    idle(30);
    vectors++;
    if (got.size() != 16) begin
      miscompares++;
      $display("[TB] FAIL fill_count: got %0d responses, required 16", got.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got[i].cmd !== exp_q[i].cmd || got[i].data !== exp_q[i].data ||
          got[i].rtn !== exp_q[i].rtn || got[i].scmd !== 4'd0) begin
        miscompares++;
        $display("[TB] FAIL fill_resp[%0d]: got cmd=%0d rtn=%h, required cmd=%0d rtn=%h",
                 i, got[i].cmd, got[i].rtn, exp_q[i].cmd, exp_q[i].rtn);
      end
    end
  endtask

  task automatic test_wr_rd();
    int n0;
    got.delete();
    exp_q.delete();
    n0 = cyc;
    drive_req(WR, 8, 64'hDEADBEEF_00000001, 32'd7, 1'b1);
    mc_rq_vadr = 48'h40;
    tick();
    drive_req(RD, 8, 64'd0, 32'd8, 1'b1);
    mc_rq_vadr = 48'h40;
    tick();
    idle(15);
    vectors++;
    if (got.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL wr_rd_count: got %0d responses, required 2", got.size());
    end else begin
      vectors++;
      if (got[0].cyc != n0 + LAT + 2 || got[0].cmd !== WRCMP || got[0].rtn !== 32'd7 ||
          got[0].data !== 64'd0) begin
        miscompares++;
        $display("[TB] FAIL wr_rd_wrcmp: got cyc=%0d cmd=%0d rtn=%0d data=%h, required cyc=%0d cmd=3 rtn=7 data=0",
                 got[0].cyc, got[0].cmd, got[0].rtn, got[0].data, n0 + LAT + 2);
      end
      vectors++;
      if (got[1].cyc != n0 + LAT + 3 || got[1].cmd !== RDATA || got[1].rtn !== 32'd8 ||
          got[1].data !== 64'hDEADBEEF_00000001) begin
        miscompares++;
        $display("[TB] FAIL wr_rd_rdata: got cyc=%0d cmd=%0d rtn=%0d data=%h, required cyc=%0d cmd=2 rtn=8 data=deadbeef00000001",
                 got[1].cyc, got[1].cmd, got[1].rtn, got[1].data, n0 + LAT + 3);
      end
    end
  endtask

  task automatic test_unsup();
    got.delete();
    for (int i = 0; i < 2; i++) begin
      drive_req(3'd5, 2, 64'd0, 32'(50 + i), 1'b1);
      tick();
    end
    idle(12);
    vectors++;
    if (err_unsup_cnt !== 16'd2 || got.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL unsup: got err_unsup_cnt=%0d responses=%0d, required 2 and 0",
               err_unsup_cnt, got.size());
    end
  endtask

  task automatic test_flow_control();
    int  issued = 0;
    bit  saw_stall = 1'b0;
    int  got_during = -1;
    got.delete();
    exp_q.delete();
    for (int t = 0; t < 600 && !(issued == 20 && got.size() >= 20); t++) begin
      mc_rs_stall = (t < 30);
      if (mc_rq_stall) saw_stall = 1'b1;
      if (issued < 20 && !mc_rq_stall) begin
        drive_req(RD, $urandom_range(0, 15), 64'd0, $urandom, 1'b1);
        issued++;
      end else mc_rq_vld = 1'b0;
      tick();
      if (t == 29) got_during = got.size();
    end
    mc_rs_stall = 1'b0;
    idle(10);
    vectors++;
    if (!saw_stall || got_during != 0) begin
      miscompares++;
      $display("[TB] FAIL flow_stall: got rq_stall_seen=%0d responses_while_stalled=%0d, required 1 and 0",
               saw_stall, got_during);
    end
    vectors++;
    if (got.size() != 20 || ovf_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flow_count: got %0d responses ovf_err=%b, required 20 and 0",
               got.size(), ovf_err);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got[i].cmd !== exp_q[i].cmd || got[i].data !== exp_q[i].data || got[i].rtn !== exp_q[i].rtn) begin
        miscompares++;
        $display("[TB] FAIL flow_resp[%0d]: got data=%h rtn=%h, required data=%h rtn=%h",
                 i, got[i].data, got[i].rtn, exp_q[i].data, exp_q[i].rtn);
      end
    end
  endtask

  // With responses blocked, the request queue plus the execution budget hold 2*DEPTH requests.
  task automatic test_overflow();
    got.delete();
    exp_q.delete();
    mc_rs_stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_req(RD, $urandom_range(0, 15), 64'd0, 32'(100 + i), i < 2 * DEPTH);
      tick();
    end
    idle(5);
    vectors++;
    if (ovf_err !== 1'b1 || got.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL ovf_flag: got ovf_err=%b responses=%0d, required 1 and 0", ovf_err, got.size());
    end
    mc_rs_stall = 1'b0;
    for (int k = 0; k < 100 && got.size() < 2 * DEPTH; k++) tick();
    idle(10);
    vectors++;
    if (got.size() != 2 * DEPTH) begin
      miscompares++;
      $display("[TB] FAIL ovf_survivors: got %0d responses, required %0d", got.size(), 2 * DEPTH);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got[i].data !== exp_q[i].data || got[i].rtn !== exp_q[i].rtn) begin
        miscompares++;
        $display("[TB] FAIL ovf_resp[%0d]: got data=%h rtn=%0d, required data=%h rtn=%0d",
                 i, got[i].data, got[i].rtn, exp_q[i].data, exp_q[i].rtn);
      end
    end
  endtask

  task automatic test_flush();
    int n0;
    int m;
    got.delete();
    exp_q.delete();
    flush_cyc.delete();
    n0 = cyc;
    for (int i = 0; i < 3; i++) begin
      drive_req(WR, 1 + i, {$urandom, $urandom}, 32'(200 + i), 1'b1);
      tick();
    end
    mc_rq_vld   = 1'b0;
    mc_rq_flush = 1'b1;
    tick();
    mc_rq_flush = 1'b0;
    tick();
    mc_rq_flush = 1'b1;
    tick();
    idle(20);
    vectors++;
    if (got.size() != 3 || flush_cyc.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL flush_merge: got %0d responses %0d pulses, required 3 and 1",
               got.size(), flush_cyc.size());
    end else begin
      vectors++;
      if (got[2].cyc != n0 + 2 + LAT + 2 || flush_cyc[0] != got[2].cyc + 1) begin
        miscompares++;
        $display("[TB] FAIL flush_timing: got wrcmp3 cyc=%0d pulse cyc=%0d, required %0d and %0d",
                 got[2].cyc, flush_cyc[0], n0 + 2 + LAT + 2, n0 + 2 + LAT + 3);
      end
    end
    m = cyc;
    mc_rq_flush = 1'b1;
    tick();
    idle(5);
    vectors++;
    if (flush_cyc.size() != 2 || flush_cyc[flush_cyc.size() - 1] != m + 1) begin
      miscompares++;
      $display("[TB] FAIL flush_empty: got %0d pulses last cyc=%0d, required 2 and %0d",
               flush_cyc.size(), flush_cyc[flush_cyc.size() - 1], m + 1);
    end
  endtask

  task automatic test_reset_midflight();
    drive_req(WR, 5, {$urandom, $urandom}, 32'd300, 1'b1);
    tick();
    idle(12);
    got.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive_req(RD, i, 64'd0, 32'(400 + i), 1'b1);
      tick();
    end
    mc_rq_vld = 1'b0;
    i_reset   = 1'b1;
    @(negedge clk);
    vectors++;
    if ({mc_rs_vld, mc_rs_flush_cmplt, err_unsup_cnt, ovf_err, mc_rq_stall} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midflight_reset_outputs: got vld=%b err=%0d ovf=%b, required 0",
               mc_rs_vld, err_unsup_cnt, ovf_err);
    end
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    model_unsup = 0;
    exp_q.delete();
    idle(15);
    vectors++;
    if (got.size() != 0 || err_unsup_cnt !== 16'd0 || ovf_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midflight_discard: got responses=%0d err=%0d ovf=%b, required 0",
               got.size(), err_unsup_cnt, ovf_err);
    end
    drive_req(RD, 5, 64'd0, 32'd500, 1'b1);
    tick();
    idle(12);
    vectors++;
    if (got.size() != 1 || got[0].data !== exp_q[0].data || got[0].rtn !== 32'd500) begin
      miscompares++;
      $display("[TB] FAIL midflight_retained: got %0d responses data=%h, required 1 data=%h",
               got.size(), got.size() > 0 ? got[0].data : 64'd0, exp_q[0].data);
    end
  endtask

  task automatic test_random();
    int         issued = 0;
    int         r;
    int         u;
    logic [2:0] c;
    got.delete();
    exp_q.delete();
    for (int t = 0; t < 3000 && issued < 200; t++) begin
      mc_rs_stall = ($urandom_range(0, 3) == 0);
      if (!mc_rq_stall && $urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          u = $urandom_range(3, 8);
          c = (u == 8) ? 3'd0 : 3'(u);
        end else c = (r < 5) ? WR : RD;
        drive_req(c, $urandom_range(0, 15), {$urandom, $urandom}, $urandom, 1'b1);
        issued++;
      end else mc_rq_vld = 1'b0;
      tick();
    end
    mc_rs_stall = 1'b0;
    idle(1);
    for (int k = 0; k < 200 && got.size() < exp_q.size(); k++) tick();
    idle(5);
    vectors++;
    if (issued != 200 || got.size() != exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL random_count: got issued=%0d responses=%0d, required 200 and %0d",
               issued, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got[i].cmd !== exp_q[i].cmd || got[i].data !== exp_q[i].data ||
          got[i].rtn !== exp_q[i].rtn || got[i].scmd !== 4'd0) begin
        miscompares++;
        $display("[TB] FAIL random_resp[%0d]: got cmd=%0d data=%h rtn=%h, required cmd=%0d data=%h rtn=%h",
                 i, got[i].cmd, got[i].data, got[i].rtn, exp_q[i].cmd, exp_q[i].data, exp_q[i].rtn);
      end
    end
    vectors++;
    if (err_unsup_cnt !== 16'(model_unsup) || ovf_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL random_counters: got err=%0d ovf=%b, required err=%0d ovf=0",
               err_unsup_cnt, ovf_err, model_unsup);
    end
  endtask

  initial begin
    i_reset      = 1'b1;
    mc_rq_vld    = 1'b0;
    mc_rq_cmd    = 3'd0;
    mc_rq_scmd   = 4'd0;
    mc_rq_vadr   = 48'd0;
    mc_rq_size   = 2'd0;
    mc_rq_rtnctl = 32'd0;
    mc_rq_data   = 64'd0;
    mc_rq_flush  = 1'b0;
    mc_rs_stall  = 1'b0;
    $display("[TB] starting mc_port_responder bench");
    test_reset();
    test_fill();
    test_wr_rd();
    test_unsup();
    test_flow_control();
    test_overflow();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_port_responder.md
MC_PORT_RESPONDER -- requirements
Module: mc_port_responder

Interface
REQ-001 Parameters SHALL be: RTNCTL_WIDTH, default 32, rtnctl width; MEM_AW, default 8, log2 of 64-bit word count; LATENCY, default 4, execute-to-response cycles (≥1); FIFO_DEPTH, default 8, entries per queue (power of 2); STALL_MARGIN, default 2, free-entry threshold for stall.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 i_reset  in  1  reset, asynchronous, active-high.
REQ-004 mc_rq_vld  in  1  request valid, one request per cycle.
REQ-005 mc_rq_cmd  in  3  1=RD, 2=WR; all other values unsupported.
REQ-006 mc_rq_scmd  in  4  ignored.
REQ-007 mc_rq_vadr  in  48  byte address; word index = vadr[MEM_AW+2:3].
REQ-008 mc_rq_size  in  2  ignored; every access is 8 bytes.
REQ-009 mc_rq_rtnctl  in  RTNCTL_WIDTH  tag, echoed unchanged in the response.
REQ-010 mc_rq_data  in  64  write data.
REQ-011 mc_rq_flush  in  1  flush request pulse.
REQ-012 mc_rq_stall  out  1  backpressure to requester.
REQ-013 mc_rs_vld / mc_rs_cmd / mc_rs_scmd / mc_rs_data / mc_rs_rtnctl  out  1/3/4/64/RTNCTL_WIDTH  response; cmd 2=read data, 3=write complete; scmd is always 0; data is 0 for write complete.
REQ-014 mc_rs_stall  in  1  requester refuses responses this cycle.
REQ-015 mc_rs_flush_cmplt  out  1  one-cycle flush-done pulse.
REQ-016 err_unsup_cnt  out  16  count of unsupported commands, saturates at 0xFFFF; ovf_err  out  1  sticky request-queue overflow flag.

Function
REQ-017 Each cycle with mc_rq_vld=1 SHALL push the request into the request FIFO (RQF) regardless of mc_rq_stall.
REQ-018 mc_rq_stall SHALL be registered, and SHALL be 1 in the cycle after the RQF free-entry count becomes ≤STALL_MARGIN.
REQ-019 A push to a full RQF SHALL drop the request and set ovf_err; only reset clears ovf_err.
REQ-020 The RQF head SHALL be popped (executed) only when resp-FIFO occupancy plus in-flight pipeline entries < FIFO_DEPTH; at most one pop per cycle.
REQ-021 Execute of WR SHALL write mem[idx] in the pop cycle; RD SHALL read mem[idx] in the pop cycle; requests execute strictly in arrival order, so a RD after a WR to the same idx returns the new data.
REQ-022 An unsupported cmd SHALL be popped, increment err_unsup_cnt, and produce no response.
REQ-023 Executed RD/WR entries SHALL traverse a LATENCY-stage shift pipeline, then enqueue into the response FIFO (RSF).
REQ-024 mc_rs_vld SHALL be 1 in a cycle iff RSF is non-empty and mc_rs_stall=0; each such cycle pops one RSF entry.
REQ-025 With all queues empty and no stalls, mc_rs_vld SHALL assert exactly LATENCY+2 cycles after the request cycle (6 cycles at default).
REQ-026 Simultaneous RQF push and pop SHALL both succeed, with occupancy unchanged, including when the RQF is full; the same rule SHALL apply to the RSF.
REQ-027 Flush: mc_rq_flush SHALL set flush_pending; while pending, mc_rs_flush_cmplt SHALL pulse for exactly one cycle in the first cycle that RQF, pipeline and RSF are all empty and no push occurs, then clear pending.
REQ-028 Flushes arriving while pending SHALL merge into one completion.
REQ-029 A flush arriving with everything empty SHALL complete in the next cycle.
REQ-030 Memory contents SHALL be undefined at power-up and SHALL NOT be cleared by reset.

Reset
REQ-031 Asserting i_reset at any time, including mid-operation, SHALL immediately empty RQF, pipeline and RSF, discarding in-flight requests without responses.
REQ-032 Reset SHALL clear flush_pending, err_unsup_cnt and ovf_err.
REQ-033 All outputs SHALL be 0 during reset and in the first cycle after deassertion.

Structure
REQ-034 A shared package mc_resp_pkg SHALL hold the RD/WR command codes, the RDATA/WRCMP response codes, and the word-index extraction width rule.
REQ-035 One sub-module, mc_sync_fifo (parameterised width/depth, count output), SHALL be instantiated twice, as RQF and RSF.

Verification
REQ-036 WR vadr 0x40 data 0xDEADBEEF_00000001 rtnctl 7, then RD 0x40 rtnctl 8 -> WRCMP rtnctl 7 at request cycle+6, then RDATA 0xDEADBEEF_00000001 rtnctl 8 next cycle.
REQ-037 Hold mc_rs_stall=1 while issuing 20 back-to-back RDs and honouring mc_rq_stall -> mc_rq_stall rises, no response while stalled; after release all 20 responses arrive in order with ovf_err=0.
REQ-038 Ignore mc_rq_stall and issue 20 RDs with mc_rs_stall=1 -> ovf_err=1, and exactly the surviving requests respond.
REQ-039 Three WRs then mc_rq_flush, plus a second flush 2 cycles later -> exactly one mc_rs_flush_cmplt pulse, one cycle after the third WRCMP is delivered.
REQ-040 cmd=5 twice -> err_unsup_cnt=2, no mc_rs_vld.
REQ-041 Assert i_reset with 4 requests in flight -> no responses after reset, counters 0, and a subsequent RD of a previously written address returns the stored data.
